// File: rtl/da_lut_precompute_if.sv
// Tap-write, start and table-stream signals between the DA LUT generator and its neighbours.
// The DA LUT generator connects through the slave modport; the controller side uses master.
interface da_lut_precompute_if #(
    parameter int unsigned COEF_W = 16,
    parameter int unsigned LUT_W  = 19,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned TAP_AW = 6
);
    logic              coef_we;
    logic [TAP_AW-1:0] coef_addr;
    logic [COEF_W-1:0] coef_din;
    logic              start;
    logic              lut_ready;
    logic              lut_valid;
    logic [ADDR_W-1:0] caddr;
    logic [LUT_W-1:0]  cin;
    logic              cload;
    logic              busy;
    logic              done;

    modport master (
        output coef_we, coef_addr, coef_din, start, lut_ready,
        input  lut_valid, caddr, cin, cload, busy, done
    );

    modport slave (
        input  coef_we, coef_addr, coef_din, start, lut_ready,
        output lut_valid, caddr, cin, cload, busy, done
    );
endinterface

// File: rtl/da_lut_precompute.sv
// Generates the distributed-arithmetic partial-sum table for fir_filter, one entry per cycle.
// Entries within a group walk Gray-code order so each needs a single add or subtract.
module da_lut_precompute #(
    parameter int unsigned NUM_GROUPS = 8,
    parameter int unsigned GROUP_TAPS = 8,
    parameter int unsigned COEF_W     = 16,
    parameter int unsigned LUT_W      = 19,
    parameter int unsigned ADDR_W     = 11
) (
    input logic             clk_fast,
    input logic             reset,
    da_lut_precompute_if.slave bus
);
    localparam int unsigned GRP_W    = $clog2(NUM_GROUPS);
    localparam int unsigned STEP_W   = GROUP_TAPS;
    localparam int unsigned BIT_W    = $clog2(GROUP_TAPS);
    localparam int unsigned NUM_TAPS = NUM_GROUPS * GROUP_TAPS;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e                    state_q, state_d;
    logic [GRP_W-1:0]          k_q, k_d;
    logic [STEP_W-1:0]         p_q, p_d;
    logic [ADDR_W-1:0]         caddr_q, caddr_d;
    logic signed [LUT_W-1:0]   cin_q, cin_d;
    logic                      lut_valid_q, lut_valid_d;
    logic                      cload_q, cload_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic signed [COEF_W-1:0]  tap_q [NUM_TAPS];

    logic [STEP_W-1:0]         p_nxt, g_nxt;
    logic [GRP_W-1:0]          k_nxt;
    logic [BIT_W-1:0]          b_nxt;
    logic signed [COEF_W-1:0]  tap_sel;
    logic                      last_step;
    logic                      xfer;

    // Next Gray step: the lowest set bit of p selects the single tap that toggles.
    always_comb begin
        p_nxt = p_q + STEP_W'(1);
        k_nxt = (p_q == '1) ? k_q + GRP_W'(1) : k_q;
        g_nxt = p_nxt ^ (p_nxt >> 1);
        b_nxt = '0;
        for (int i = STEP_W - 1; i >= 0; i--) begin
            if (p_nxt[i]) b_nxt = BIT_W'(i);
        end
        tap_sel = tap_q[{k_nxt, b_nxt}];
    end

    assign last_step = (k_q == GRP_W'(NUM_GROUPS - 1)) && (p_q == '1);
    assign xfer      = lut_valid_q && bus.lut_ready;

    always_ff @(posedge clk_fast) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            p_q         <= '0;
            caddr_q     <= '0;
            cin_q       <= '0;
            lut_valid_q <= 1'b0;
            cload_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            p_q         <= p_d;
            caddr_q     <= caddr_d;
            cin_q       <= cin_d;
            lut_valid_q <= lut_valid_d;
            cload_q     <= cload_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        p_d         = p_q;
        caddr_d     = caddr_q;
        cin_d       = cin_q;
        lut_valid_d = lut_valid_q;
        cload_d     = cload_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_RUN;
                    k_d         = '0;
                    p_d         = '0;
                    caddr_d     = '0;
                    cin_d       = '0;
                    lut_valid_d = 1'b1;
                    cload_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (last_step) begin
                        state_d     = S_DONE;
                        lut_valid_d = 1'b0;
                        cload_d     = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        k_d     = k_nxt;
                        p_d     = p_nxt;
                        caddr_d = {k_nxt, g_nxt};
                        if (p_nxt == '0)
                            cin_d = '0;
                        else if (g_nxt[b_nxt])
                            cin_d = cin_q + LUT_W'(tap_sel);
                        else
                            cin_d = cin_q - LUT_W'(tap_sel);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tap file is writable only while idle so a run sees a frozen coefficient set.
    always_ff @(posedge clk_fast) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) tap_q[i] <= '0;
        end else if (state_q == S_IDLE && bus.coef_we) begin
            tap_q[bus.coef_addr] <= bus.coef_din;
        end
    end

    assign bus.lut_valid = lut_valid_q;
    assign bus.caddr     = caddr_q;
    assign bus.cin       = cin_q;
    assign bus.cload     = cload_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_da_lut_precompute.sv
// Scoreboard bench for da_lut_precompute: expected table pushed at start, monitor pops on each transfer.
module tb_da_lut_precompute;
    localparam int NENT = 2048;

    typedef struct packed {
        logic [10:0] addr;
        logic [18:0] cin;
    } entry_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    da_lut_precompute_if bus ();
    da_lut_precompute dut (.clk_fast(clk), .reset(reset), .bus(bus));

    entry_t      sb[$];
    entry_t      mon_e;
    int          taps[64];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          run_xfers = 0;
    int          done_cnt = 0;
    int          rdy_mode = 0;
    bit          chk_timing = 1'b0;
    logic [18:0] cap[NENT];
    int          seen[NENT];
    bit          stalled = 1'b0;
    logic [10:0] prev_addr;
    logic [18:0] prev_cin;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: a table entry is the plain sum of the taps selected by the low 8 address bits.
    function automatic logic [18:0] model_cin(input int a);
        int s = 0;
        int k = a / 256;
        int g = a % 256;
        for (int b = 0; b < 8; b++) if (((g >> b) & 1) == 1) s += taps[8 * k + b];
        return s[18:0];
    endfunction

    task automatic build_expected();
        sb.delete();
        for (int n = 0; n < NENT; n++) begin
            int k = n / 256;
            int p = n % 256;
            int a = k * 256 + (p ^ (p >> 1));
            sb.push_back('{addr: 11'(a), cin: model_cin(a)});
            seen[n] = 0;
            cap[n]  = '0;
        end
        run_xfers = 0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) bus.lut_ready = ~bus.lut_ready;
        else if (rdy_mode == 2) bus.lut_ready = 1'($urandom_range(0, 1));
        else bus.lut_ready = 1'b1;
    end

    // Monitor: stall stability, entry compare on every transfer, done-pulse compare.
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("stall_hold", 32'({bus.lut_valid, bus.caddr, bus.cin}), 32'({1'b1, prev_addr, prev_cin}));
            if (bus.lut_valid && bus.lut_ready) begin
                if (sb.size() == 0) begin
                    check("extra_entry", 32'(1), 32'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check("entry", {bus.caddr, bus.cin, bus.cload, bus.busy}, {mon_e.addr, mon_e.cin, 2'b11});
                    if (chk_timing) check("entry_cycle", 32'(cyc), 32'(t0 + 1 + run_xfers));
                    cap[bus.caddr]  = bus.cin;
                    seen[bus.caddr] = seen[bus.caddr] + 1;
                end
                run_xfers++;
            end
            stalled   = bus.lut_valid && !bus.lut_ready;
            prev_addr = bus.caddr;
            prev_cin  = bus.cin;
            if (bus.done) begin
                check("done_after_last", 32'({sb.size() == 0, run_xfers == NENT, bus.lut_valid, bus.cload, bus.busy}),
                      32'(5'b11001));
                if (chk_timing) check("done_cycle", 32'(cyc), 32'(t0 + 2049));
                done_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) taps[i] = 0;
    endtask

    task automatic write_tap(input int a, input int v);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 6'(a);
        bus.coef_din  = 16'(v);
        taps[a]       = v;
        tick();
        bus.coef_we = 1'b0;
    endtask

    task automatic start_run(input bit timing);
        build_expected();
        chk_timing = timing;
        bus.start  = 1'b1;
        t0         = cyc;
        tick();
        bus.start   = 1'b0;
        bus.coef_we = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int  d0 = done_cnt;
        bit  got = 1'b0;
        for (int i = 0; i < 6000 && !got; i++) begin
            tick();
            got = (done_cnt != d0);
        end
        if (!got) check({name, "_timeout"}, 32'(0), 32'(1));
        check({name, "_idle_busy"}, 32'(bus.busy), 32'(0));
    endtask

    task automatic check_once(input string name);
        int bad = 0;
        for (int a = 0; a < NENT; a++) if (seen[a] != 1) bad++;
        check(name, 32'(bad), 32'(0));
    endtask

    initial begin
        void'($urandom(32'd20240611));
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_din  = '0;
        bus.start     = 1'b0;
        do_reset();
        @(negedge clk);
        check("reset_flags", 32'({bus.lut_valid, bus.cload, bus.busy, bus.done}), 32'(0));
        check("reset_data", 32'({bus.caddr, bus.cin}), 32'(0));
        tick();

        // All taps 1: entry = popcount, back-to-back timing.
        rdy_mode = 0;
        for (int i = 0; i < 64; i++) write_tap(i, 1);
        start_run(1'b1);
        wait_done("ones");
        check("ones_c255", 32'(cap[255]), 32'(8));
        check("ones_c256", 32'(cap[256]), 32'(0));
        check_once("ones_once");

        // Extreme taps: full negative and positive range.
        for (int i = 0; i < 64; i++) write_tap(i, (i < 8) ? -32768 : ((i < 16) ? 32767 : 0));
        start_run(1'b1);
        wait_done("ext");
        check("ext_c255", 32'(cap[255]), 32'(19'h40000));
        check("ext_c511", 32'(cap[511]), 32'(19'(262136)));
        check("ext_c1023", 32'(cap[1023]), 32'(0));

        // Random taps with stalls; start and tap write mid-run must be ignored.
        for (int i = 0; i < 64; i++) write_tap(i, int'($urandom_range(0, 65535)) - 32768);
        write_tap(3, 7);
        rdy_mode = 1;
        start_run(1'b0);
        repeat (300) tick();
        bus.start     = 1'b1;
        bus.coef_we   = 1'b1;
        bus.coef_addr = 6'd3;
        bus.coef_din  = 16'd100;
        tick();
        bus.start   = 1'b0;
        bus.coef_we = 1'b0;
        wait_done("rand");
        check_once("rand_once");
        rdy_mode = 2;
        start_run(1'b0);
        wait_done("rand2");
        check_once("rand2_once");

        // Reset at the 1000th transfer, then restart without reload.
        rdy_mode = 0;
        start_run(1'b0);
        for (int i = 0; i < 3000 && run_xfers < 1000; i++) tick();
        check("mid_reach_1000", 32'(run_xfers >= 1000), 32'(1));
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_flags", 32'({bus.lut_valid, bus.cload, bus.busy, bus.done}), 32'(0));
        check("mid_rst_caddr", 32'(bus.caddr), 32'(0));
        check("mid_rst_cin", 32'(bus.cin), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < 64; i++) taps[i] = 0;
        start_run(1'b1);
        wait_done("zero");
        begin
            int nz = 0;
            for (int a = 0; a < NENT; a++) if (cap[a] != 0) nz++;
            check("zero_all", 32'(nz), 32'(0));
        end

        // Tap write and start in the same cycle: write lands first.
        do_reset();
        taps[0]       = 5;
        bus.coef_we   = 1'b1;
        bus.coef_addr = 6'd0;
        bus.coef_din  = 16'd5;
        start_run(1'b1);
        wait_done("same");
        check("same_c1", 32'(cap[1]), 32'(5));
        check("same_c0", 32'(cap[0]), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/da_lut_precompute.md
Name: da_lut_precompute

Overview:
- Upstream stage of fir_filter: generates the 2048-entry distributed-arithmetic partial-sum table and streams it into the filter's CIN/CADDR/CLOAD load port.
- Holds 64 signed 16-bit taps written over a simple register port.
- On start, emits one table entry per cycle in Gray-code order. Each group's entries come from a single add/subtract accumulator.

Parameters:
- NUM_GROUPS, 8: tap groups, one 256-entry sub-table each.
- GROUP_TAPS, 8: taps per group; sub-table depth is 2^GROUP_TAPS.
- COEF_W, 16: signed tap width.
- LUT_W, 19: signed table entry width; equals COEF_W + log2(GROUP_TAPS).
- ADDR_W, 11: table address width; equals log2(NUM_GROUPS) + GROUP_TAPS.

Ports:
- clk_fast  in  1  clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- coef_we  in  1  tap write strobe; honoured only in IDLE.
- coef_addr  in  6  tap index 0..63.
- coef_din  in  16  signed tap value.
- start  in  1  begin table generation; honoured only in IDLE.
- lut_ready  in  1  downstream accepts the current entry.
- lut_valid  out  1  caddr/cin hold a valid entry.
- caddr  out  11  table address (drives fir_filter CADDR).
- cin  out  19  signed partial sum (drives fir_filter CIN).
- cload  out  1  load-mode level (drives fir_filter CLOAD).
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the last entry is accepted.

Behaviour:
- Clock and reset are decided: one clock, clk_fast; reset is synchronous and active-high. Every output and the tap file are updated only on clk_fast.
- Reset (including mid-run) puts the block in IDLE and drives:
  - lut_valid, cload, busy, done, caddr, cin all to 0;
  - all 64 taps cleared to 0.
- IDLE:
  - coef_we writes coef_din to tap[coef_addr] on the clock edge.
  - If coef_we and start are high in the same cycle, the write lands first; generation uses the new value.
  - start goes to RUN and loads group k=0, step p=0, accumulator 0.
- RUN: entry for (k, p) is
  - caddr = k*256 + g, where g = p ^ (p>>1);
  - cin = sum of tap[8k+b] over every set bit b of g.
  - p=0 of each group: accumulator = 0.
  - p>0: b = index of the lowest set bit of p. Add tap[8k+b] if bit b of g is 1, otherwise subtract it.
  - Arithmetic is signed LUT_W. Range is -262144..+262136, so no overflow and no saturation is needed.
- Handshake:
  - Entry is transferred when lut_valid && lut_ready.
  - While lut_ready is low, caddr and cin hold stable and lut_valid stays high.
  - The next entry appears the cycle after a transfer.
- Latency:
  - start sampled at cycle t gives the first entry (caddr 0, cin 0) at t+1.
  - With lut_ready held high, entry n appears at t+1+n; the final entry (n=2047) appears at t+2048.
- Group wrap: after p=255, k increments and p resets to 0 with the accumulator cleared. No bubble cycle.
- cload is high from t+1 through the cycle of the last transfer, inclusive.
- DONE: entered on the cycle after the last transfer (k=7, p=255).
  - For one cycle: done=1, lut_valid=0, cload=0.
  - Then returns to IDLE.
- start and coef_we arriving during RUN or DONE are ignored; taps stay frozen.
- caddr and cin keep their last values after a run. Only reset zeroes them.

Test Plan:
- All 64 taps = 1, lut_ready=1, start:
  - 2048 entries on consecutive cycles; each cin = popcount(caddr[7:0]).
  - caddr 0 at t+1, caddr 256 at t+257, caddr 255 with cin 8 (p=170).
  - done pulses at t+2049.
- Taps 0..7 = -32768, taps 8..15 = +32767, rest 0:
  - caddr 255 → cin -262144 (19'h40000); caddr 511 → cin 262136; caddr 1023 → 0.
- Random taps (seeded), lut_ready toggled every other cycle:
  - Entries match the software sum for all 2048 addresses.
  - Values are stable during stalls; each address appears exactly once.
  - done occurs only after the 2048th transfer.
- Reset asserted at the 1000th transfer:
  - Next cycle: lut_valid=0, cload=0, busy=0, caddr=0, cin=0.
  - A restart with no reload produces all-zero cin.
- During RUN, pulse start and write coef_we addr 3 = 100:
  - Run is unaffected and the tap value is not changed.
- coef_we addr 0 = 5 and start in the same cycle:
  - caddr 1 → cin 5.
